// File: rtl/cmul_drain_fifo.sv
// cmul_drain_fifo
//   Reader end of the complex-multiplier delay pipeline. The multiplier cannot
//   stall, so every launched multiply must have a reserved FIFO slot before it
//   is issued. This block stores the packed {re, im} results, hands them to
//   the downstream FFT stage with valid/ready, and returns credits to the
//   multiplier issue logic.
//
//   Optional feature macro: CMUL_DRAIN_PEAK_EN (adds PEAK / PEAK_CLR).
//
// Ports
//   CLK          clock, rising edge
//   RST_N        asynchronous active-low reset
//   ISSUE        upstream launched one multiply this cycle
//   ISSUE_READY  a credit is available for a new multiply
//   IN_VALID     multiplier delivers a result this cycle
//   C            packed result {re[15:0], im[15:0]}
//   OUT_DATA     head-of-FIFO data (zero while empty)
//   OUT_VALID    FIFO not empty
//   OUT_READY    downstream accepts OUT_DATA
//   COUNT        stored entries
//   INFLIGHT     issued multiplies not yet delivered
//   OVERFLOW     sticky: write while full, or issue without credit
//   UNDERFLOW    sticky: result delivered with nothing in flight
//   PEAK_CLR     (CMUL_DRAIN_PEAK_EN) reload PEAK with the next COUNT
//   PEAK         (CMUL_DRAIN_PEAK_EN) high-water mark of COUNT

module cmul_drain_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          ISSUE,
    output logic          ISSUE_READY,
    input  logic          IN_VALID,
    input  logic [DW-1:0] C,
    output logic [DW-1:0] OUT_DATA,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [AW:0]   COUNT,
    output logic [AW:0]   INFLIGHT,
    output logic          OVERFLOW,
`ifdef CMUL_DRAIN_PEAK_EN
    input  logic          PEAK_CLR,
    output logic [AW:0]   PEAK,
`endif
    output logic          UNDERFLOW
);

    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW+1:0] DEPTH_W  = (AW+2)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic [AW:0]   count_nxt;
    logic [AW:0]   inflight_q;
    logic [AW:0]   inflight_nxt;
    logic [AW+1:0] occupancy;
    logic          ovf_q;
    logic          unf_q;
    logic          full;
    logic          push;
    logic          pop;
    logic          issue_ok;
    logic          deliver;
    logic          set_ovf;
    logic          set_unf;

    // Handshake decode
    assign full      = (count_q == FULL_CNT);
    assign pop       = OUT_VALID && OUT_READY;
    // A write into a full FIFO is still accepted when the head leaves in the
    // same cycle.
    assign push      = IN_VALID && (!full || pop);
    // Credits come only from registered COUNT/INFLIGHT, so a pop this cycle
    // frees its credit one cycle later and OUT_READY never reaches ISSUE_READY.
    assign occupancy = {1'b0, count_q} + {1'b0, inflight_q};
    assign ISSUE_READY = (occupancy < DEPTH_W);
    assign issue_ok  = ISSUE && ISSUE_READY;
    // INFLIGHT saturates at zero when an unexpected result shows up.
    assign deliver   = IN_VALID && (inflight_q != '0);
    assign set_ovf   = (IN_VALID && full && !pop) || (ISSUE && !ISSUE_READY);
    assign set_unf   = IN_VALID && (inflight_q == '0);

    always_comb begin
        count_nxt = count_q;
        if (push && !pop)
            count_nxt = count_q + CNT_ONE;
        else if (!push && pop)
            count_nxt = count_q - CNT_ONE;
    end

    always_comb begin
        inflight_nxt = inflight_q;
        if (issue_ok && !deliver)
            inflight_nxt = inflight_q + CNT_ONE;
        else if (!issue_ok && deliver)
            inflight_nxt = inflight_q - CNT_ONE;
    end

    // Storage: data only, never reset
    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= C;
    end

    // Control state
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            count_q    <= count_nxt;
            inflight_q <= inflight_nxt;
            ovf_q      <= ovf_q | set_ovf;
            unf_q      <= unf_q | set_unf;
        end
    end

`ifdef CMUL_DRAIN_PEAK_EN
    logic [AW:0] peak_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            peak_q <= '0;
        else if (PEAK_CLR || (count_nxt > peak_q))
            peak_q <= count_nxt;
    end

    assign PEAK = peak_q;
`endif

    // Outputs
    assign OUT_VALID = (count_q != '0);
    // An empty FIFO presents zero so the bus is clean in and after reset
    // even though the RAM itself is never cleared.
    assign OUT_DATA  = OUT_VALID ? mem[rd_ptr] : '0;
    assign COUNT     = count_q;
    assign INFLIGHT  = inflight_q;
    assign OVERFLOW  = ovf_q;
    assign UNDERFLOW = unf_q;

endmodule

// File: tb/tb_cmul_drain_fifo.sv
module tb_cmul_drain_fifo;

    localparam int DW = 32;
    localparam int DEPTH = 8;
    localparam int AW = 3;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          ISSUE = 1'b0;
    logic          ISSUE_READY;
    logic          IN_VALID = 1'b0;
    logic [DW-1:0] C = '0;
    logic [DW-1:0] OUT_DATA;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b0;
    logic [AW:0]   COUNT;
    logic [AW:0]   INFLIGHT;
    logic          OVERFLOW;
    logic          UNDERFLOW;
`ifdef CMUL_DRAIN_PEAK_EN
    logic          PEAK_CLR = 1'b0;
    logic [AW:0]   PEAK;
`endif

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] sb[$];

    cmul_drain_fifo #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .ISSUE(ISSUE),
        .ISSUE_READY(ISSUE_READY),
        .IN_VALID(IN_VALID),
        .C(C),
        .OUT_DATA(OUT_DATA),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .COUNT(COUNT),
        .INFLIGHT(INFLIGHT),
        .OVERFLOW(OVERFLOW),
`ifdef CMUL_DRAIN_PEAK_EN
        .PEAK_CLR(PEAK_CLR),
        .PEAK(PEAK),
`endif
        .UNDERFLOW(UNDERFLOW)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: the pop happens at the next rising edge, so sample on the
    // falling edge while OUT_VALID/OUT_READY/OUT_DATA are stable.
    always @(negedge CLK) begin
        if (RST_N && OUT_VALID && OUT_READY) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL pop_unexpected: got %0h expected none", OUT_DATA);
            end else begin
                logic [DW-1:0] exp_d;
                exp_d = sb.pop_front();
                if (OUT_DATA !== exp_d) begin
                    fails++;
                    $display("FAIL pop_data: got %0h expected %0h", OUT_DATA, exp_d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        ISSUE = 1'b0;
        IN_VALID = 1'b0;
        OUT_READY = 1'b0;
        repeat (3) tick();
        sb.delete();
        RST_N = 1'b1;
    endtask

    task automatic issue_n(input int n);
        for (int i = 0; i < n; i++) begin
            ISSUE = 1'b1;
            tick();
        end
        ISSUE = 1'b0;
    endtask

    task automatic deliver_n(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            IN_VALID = 1'b1;
            C = base + DW'(i);
            sb.push_back(C);
            tick();
        end
        IN_VALID = 1'b0;
    endtask

    task automatic drain_n(input int n);
        OUT_READY = 1'b1;
        repeat (n) tick();
        OUT_READY = 1'b0;
    endtask

    initial begin
        // Reset then idle
        #1;
        do_reset();
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_issue_ready", ISSUE_READY, 1);
        chk("rst_count", COUNT, 0);
        chk("rst_inflight", INFLIGHT, 0);
        chk("rst_ovf", OVERFLOW, 0);
        chk("rst_unf", UNDERFLOW, 0);
        chk("rst_out_data", OUT_DATA, 0);

        // Basic flow
        issue_n(1);
        chk("basic_inflight", INFLIGHT, 1);
        repeat (4) tick();
        IN_VALID = 1'b1;
        C = 32'h1234_ABCD;
        OUT_READY = 1'b1;
        sb.push_back(C);
        #1;
        chk("basic_no_fallthru", OUT_VALID, 0);
        tick();
        IN_VALID = 1'b0;
        chk("basic_valid", OUT_VALID, 1);
        chk("basic_data", OUT_DATA, 32'h1234_ABCD);
        chk("basic_count1", COUNT, 1);
        chk("basic_inflight0", INFLIGHT, 0);
        tick();
        OUT_READY = 1'b0;
        chk("basic_count0", COUNT, 0);
        chk("basic_valid0", OUT_VALID, 0);

        // Backpressure fill: issue every cycle while credits last,
        // results return 5 cycles after issue.
        for (int c = 0; c < 16; c++) begin
            chk($sformatf("bp_ready_c%0d", c), ISSUE_READY, (c < 8) ? 1 : 0);
            ISSUE = (c < 8);
            IN_VALID = (c >= 5 && c < 13);
            C = DW'(c - 5);
            if (IN_VALID) sb.push_back(C);
            tick();
        end
        ISSUE = 1'b0;
        IN_VALID = 1'b0;
        chk("bp_count8", COUNT, 8);
        chk("bp_inflight0", INFLIGHT, 0);
        chk("bp_ovf", OVERFLOW, 0);
        chk("bp_unf", UNDERFLOW, 0);
        OUT_READY = 1'b1;
        #1;
        chk("bp_credit_registered", ISSUE_READY, 0);
        tick();
        chk("bp_credit_back", ISSUE_READY, 1);
        chk("bp_count7", COUNT, 7);
        repeat (7) tick();
        OUT_READY = 1'b0;
        chk("bp_drained", COUNT, 0);

        // Simultaneous push and pop at full, then overflow drop
        issue_n(8);
        deliver_n(8, 32'h10);
        chk("full_count", COUNT, 8);
        IN_VALID = 1'b1;
        C = 32'hAA;
        OUT_READY = 1'b1;
        sb.push_back(C);
        tick();
        IN_VALID = 1'b0;
        OUT_READY = 1'b0;
        chk("pp_count8", COUNT, 8);
        chk("pp_ovf", OVERFLOW, 0);
        chk("pp_unf", UNDERFLOW, 1);
        IN_VALID = 1'b1;
        C = 32'hDEAD;
        tick();
        IN_VALID = 1'b0;
        chk("ovf_set", OVERFLOW, 1);
        chk("ovf_count8", COUNT, 8);
        drain_n(8);
        chk("ovf_drained", COUNT, 0);
        chk("ovf_sb_empty", sb.size(), 0);

        // Issue without credit, then asynchronous reset mid-burst
        do_reset();
        issue_n(8);
        deliver_n(3, 32'h20);
        chk("mid_count3", COUNT, 3);
        chk("mid_inflight5", INFLIGHT, 5);
        chk("mid_noready", ISSUE_READY, 0);
        issue_n(1);
        chk("issue_ovf", OVERFLOW, 1);
        chk("issue_inflight5", INFLIGHT, 5);
        IN_VALID = 1'b1;
        C = 32'h21;
        RST_N = 1'b0;
        #1;
        chk("arst_valid", OUT_VALID, 0);
        chk("arst_count", COUNT, 0);
        chk("arst_inflight", INFLIGHT, 0);
        chk("arst_ovf", OVERFLOW, 0);
        chk("arst_unf", UNDERFLOW, 0);
        chk("arst_ready", ISSUE_READY, 1);
        chk("arst_data", OUT_DATA, 0);
        sb.delete();
        IN_VALID = 1'b0;
        tick();
        RST_N = 1'b1;
        deliver_n(1, 32'h5555);
        chk("late_unf", UNDERFLOW, 1);
        chk("late_count", COUNT, 1);
        chk("late_inflight", INFLIGHT, 0);
        drain_n(1);
        chk("late_drained", COUNT, 0);

`ifdef CMUL_DRAIN_PEAK_EN
        do_reset();
        chk("peak_rst", PEAK, 0);
        issue_n(5);
        deliver_n(5, 32'h30);
        chk("peak_fill5", PEAK, 5);
        drain_n(5);
        chk("peak_hold5", PEAK, 5);
        issue_n(2);
        deliver_n(2, 32'h40);
        chk("peak_still5", PEAK, 5);
        PEAK_CLR = 1'b1;
        tick();
        PEAK_CLR = 1'b0;
        chk("peak_clr2", PEAK, 2);
        drain_n(2);
`endif

        tick();
        chk("final_sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cmul_drain_fifo.md
Name: cmul_drain_fifo

Overview:
- Reader end of the complex-multiplier delay pipeline.
- The multiplier pipeline has a fixed latency and cannot stall. This block captures its 32-bit packed results ({re[15:0], im[15:0]}) into a small FIFO.
- It presents the results to the downstream FFT stage with a valid/ready handshake.
- It issues credits back to the multiplier issue logic, so no result can arrive when there is no room for it.

Parameters:
- DW, 32, data width of one packed complex result.
- DEPTH, 8, FIFO entries; power of two, 4 to 64.
- AW, 3, pointer width; must equal log2(DEPTH).

Ports:
- CLK  input  1  single clock; all logic on its rising edge.
- RST_N  input  1  asynchronous active-low reset.
- ISSUE  input  1  upstream launched one multiply this cycle; legal only when ISSUE_READY=1.
- ISSUE_READY  output  1  a credit is available for a new multiply.
- IN_VALID  input  1  the multiplier pipeline delivers a result this cycle.
- C  input  DW  result data; sampled when IN_VALID=1.
- OUT_DATA  output  DW  head-of-FIFO data.
- OUT_VALID  output  1  the FIFO is not empty.
- OUT_READY  input  1  downstream accepts OUT_DATA this cycle.
- COUNT  output  AW+1  number of stored entries.
- INFLIGHT  output  AW+1  number of multiplies issued but not yet delivered.
- OVERFLOW  output  1  sticky error flag.
- UNDERFLOW  output  1  sticky error flag.

Behaviour:
- Reset: asynchronous, active-low.
  - While RST_N=0: pointers, COUNT, INFLIGHT, OVERFLOW and UNDERFLOW are cleared to 0.
  - OUT_VALID=0 and ISSUE_READY=1.
  - OUT_DATA is 0. Storage RAM contents are not cleared.
  - Reset mid-operation discards all stored and in-flight results. Results that arrive after reset release are counted as UNDERFLOW, because INFLIGHT is 0.
- Write: when IN_VALID=1, C is written at the write pointer and the write pointer increments modulo DEPTH.
- Read: a pop occurs when OUT_VALID=1 and OUT_READY=1. The read pointer increments modulo DEPTH.
- OUT_DATA / OUT_VALID path:
  - OUT_DATA shows the RAM entry at the read pointer. It is combinational from registered state, with no additional latency.
  - OUT_VALID = (COUNT != 0).
  - Write-to-OUT_VALID latency is 1 cycle; there is no fall-through in the same cycle.
- COUNT update, next value:
  - COUNT + push - pop.
  - Simultaneous push and pop leaves COUNT unchanged and is legal when full.
- INFLIGHT update, next value:
  - INFLIGHT + ISSUE - IN_VALID.
  - Simultaneous ISSUE and IN_VALID leaves it unchanged.
- Credit rule: ISSUE_READY = (COUNT + INFLIGHT) < DEPTH, computed in AW+2 bits.
  - A pop in the current cycle does not free a credit until the next cycle. Credit return is registered; there is no combinational OUT_READY-to-ISSUE_READY path.
- Error handling:
  - IN_VALID while COUNT=DEPTH and no pop in that cycle: set OVERFLOW, drop the write, leave pointers unchanged.
  - IN_VALID while INFLIGHT=0: set UNDERFLOW, accept the data if there is room, leave INFLIGHT at 0 (no wrap).
  - ISSUE while ISSUE_READY=0: set OVERFLOW, do not increment INFLIGHT.
  - Sticky flags clear only on reset.
- Wrap-around: pointers are AW bits and wrap naturally. Full/empty state is taken from COUNT, not from pointer comparison.
- Ordering: strictly FIFO; no reordering or data modification.

Optional Feature:
- Macro: CMUL_DRAIN_PEAK_EN
- Defined:
  - Adds output port PEAK  AW+1  bits, a high-water mark of COUNT.
  - PEAK is registered: PEAK <= max(PEAK, next COUNT). Reset value is 0.
  - PEAK is cleared when input port PEAK_CLR (1 bit, added with the macro) is 1. If PEAK_CLR=1, PEAK loads next COUNT in that cycle.
- Undefined:
  - The PEAK and PEAK_CLR ports and their logic do not exist.
  - All other behaviour is identical.

Test Plan:
- Reset then idle:
  - Hold RST_N=0 for 3 cycles, then release.
  - Required: OUT_VALID=0, ISSUE_READY=1, COUNT=0, INFLIGHT=0, flags=0.
- Basic flow, OUT_READY=1:
  - ISSUE for 1 cycle; IN_VALID with C=32'h1234_ABCD 5 cycles later.
  - Required: OUT_VALID=1 with OUT_DATA=32'h1234_ABCD exactly 1 cycle after the write, then COUNT returns to 0.
- Backpressure fill (DEPTH=8, OUT_READY=0):
  - ISSUE every cycle.
  - Required: ISSUE_READY drops after 8 issues. The 8 results 32'h0..32'h7 are stored, COUNT=8, and no OVERFLOW.
  - Then raise OUT_READY: data pops in order 0..7, and ISSUE_READY returns 1 cycle after the first pop.
- Simultaneous push and pop at full:
  - COUNT=8, IN_VALID=1 and OUT_READY=1 in the same cycle.
  - Required: COUNT stays 8, no OVERFLOW, and the new datum appears after the existing 7.
- Error injection:
  - IN_VALID with INFLIGHT=0 sets UNDERFLOW.
  - IN_VALID at COUNT=8 with OUT_READY=0 sets OVERFLOW, COUNT stays 8, and the dropped datum never appears.
  - Assert RST_N low mid-burst: all outputs return to reset values asynchronously, before the next CLK edge.
- CMUL_DRAIN_PEAK_EN:
  - Fill to 5, then drain; PEAK=5.
  - Pulse PEAK_CLR with COUNT=2; PEAK=2.
